// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with bounded grant hold: an owner keeps the resource while
// requesting, up to MAX_HOLD cycles, after which ownership is forced to rotate.
module rr_hold_arbiter #(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 8,
  localparam int IDW     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] grant,
  output logic             grant_valid,
  output logic [IDW-1:0]   grant_id,
  output logic             timeout
);

  localparam int HCW = $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);
  localparam logic [HCW-1:0] HOLD_ONE = HCW'(1);
  localparam logic [IDW-1:0] PTR_RST  = IDW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   ptr_n;
  logic [HCW-1:0]   hold_cnt;
  logic [HCW-1:0]   hold_n;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   idx;
  logic             found;
  logic [WIDTH-1:0] grant_n;
  logic             timeout_n;

  // In BUSY ptr is the owner, so one search starting after ptr serves every
  // case: the owner naturally comes last, which is what forced rotation needs.
  always_comb begin
    win   = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int i = 1; i <= WIDTH; i++) begin
      idx = IDW'((int'(ptr) + i) % WIDTH);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    hold_n    = hold_cnt;
    timeout_n = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = BUSY;
          ptr_n   = win;
          hold_n  = HOLD_ONE;
        end
      end
      BUSY: begin
        if (!req[ptr]) begin
          if (found) begin
            ptr_n  = win;
            hold_n = HOLD_ONE;
          end else begin
            state_n = IDLE;
            hold_n  = '0;
          end
        end else if (hold_cnt != HOLD_MAX) begin
          hold_n = hold_cnt + HOLD_ONE;
        end else begin
          ptr_n     = win;
          hold_n    = HOLD_ONE;
          timeout_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        hold_n  = '0;
      end
    endcase
  end

  always_comb begin
    grant_n = '0;
    if (state_n == BUSY) begin
      grant_n[ptr_n] = 1'b1;
    end
  end

  // Outputs are registered from next-state values so they move on the same
  // edge as the state and never see req combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= PTR_RST;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      hold_cnt    <= hold_n;
      grant       <= grant_n;
      grant_valid <= (state_n == BUSY);
      grant_id    <= (state_n == BUSY) ? ptr_n : '0;
      timeout     <= timeout_n;
    end
  end

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Scoreboard bench for rr_hold_arbiter: directed req vectors push hand-derived
// expectations, and a monitor compares them one edge later.
module tb_rr_hold_arbiter;

  localparam int WIDTH    = 4;
  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       timeout;

  typedef struct {
    logic [3:0] grant;
    logic       valid;
    logic [1:0] id;
    logic       to;
    int         test_no;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   test_no = 0;

  rr_hold_arbiter #(
    .WIDTH   (WIDTH),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Called at a falling edge: drives req and queues what the next rising edge must produce.
  task automatic apply_stimulus(input logic [3:0] v, input logic [3:0] g, input logic to);
    exp_t e;
    e.grant   = g;
    e.valid   = |g;
    e.id      = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) e.id = 2'(i);
    end
    e.to      = to;
    e.test_no = test_no;
    req = v;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_reset_state();
    check_output("reset_grant", 8'(grant), 8'h00);
    check_output("reset_valid", 8'(grant_valid), 8'h00);
    check_output("reset_id", 8'(grant_id), 8'h00);
    check_output("reset_timeout", 8'(timeout), 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0000;
    #1;
    check_reset_state();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_output($sformatf("t%0d_grant", mon_e.test_no), 8'(grant), 8'(mon_e.grant));
      check_output($sformatf("t%0d_valid", mon_e.test_no), 8'(grant_valid), 8'(mon_e.valid));
      check_output($sformatf("t%0d_id", mon_e.test_no), 8'(grant_id), 8'(mon_e.id));
      check_output($sformatf("t%0d_timeout", mon_e.test_no), 8'(timeout), 8'(mon_e.to));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Test 1: idle with no requests
    test_no = 1;
    do_reset();
    repeat (5) apply_stimulus(4'b0000, 4'b0000, 1'b0);

    // Test 2: all requesting, rotation every MAX_HOLD cycles starting at requester 0
    test_no = 2;
    do_reset();
    for (int c = 1; c <= 33; c++) begin
      apply_stimulus(4'b1111, 4'b0001 << (((c - 1) / 8) % 4),
                     (c > 1) && (((c - 1) % 8) == 0));
    end
    apply_stimulus(4'b0000, 4'b0000, 1'b0);

    // Test 3: short request then release to idle
    test_no = 3;
    do_reset();
    repeat (3) apply_stimulus(4'b0100, 4'b0100, 1'b0);
    repeat (2) apply_stimulus(4'b0000, 4'b0000, 1'b0);

    // Test 4: lone requester is re-granted with a timeout pulse every MAX_HOLD cycles
    test_no = 4;
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      apply_stimulus(4'b0010, 4'b0010, (c == 9) || (c == 17));
    end
    apply_stimulus(4'b0000, 4'b0000, 1'b0);

    // Test 5: release hands over without a gap cycle
    test_no = 5;
    do_reset();
    apply_stimulus(4'b0001, 4'b0001, 1'b0);
    apply_stimulus(4'b0001, 4'b0001, 1'b0);
    apply_stimulus(4'b1010, 4'b0010, 1'b0);
    apply_stimulus(4'b1010, 4'b0010, 1'b0);
    apply_stimulus(4'b1000, 4'b1000, 1'b0);
    apply_stimulus(4'b0000, 4'b0000, 1'b0);

    // Test 6: asynchronous reset in mid-grant, then reset priority order
    test_no = 6;
    do_reset();
    apply_stimulus(4'b0100, 4'b0100, 1'b0);
    apply_stimulus(4'b0100, 4'b0100, 1'b0);
    @(posedge clk);
    #3;
    check_output("t6_pre_reset_grant", 8'(grant), 8'h04);
    rst = 1'b1;
    #1;
    check_reset_state();
    req = 4'b1100;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(4'b1100, 4'b0100, 1'b0);
    apply_stimulus(4'b1100, 4'b0100, 1'b0);
    apply_stimulus(4'b1000, 4'b1000, 1'b0);
    apply_stimulus(4'b0000, 4'b0000, 1'b0);

    repeat (2) @(negedge clk);
    check_output("scoreboard_drained", 8'(exp_q.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_hold_arbiter.md
# rr_hold_arbiter

Sequential round-robin arbiter that shares one resource between WIDTH requesters. A grant is held for as long as the owner keeps its request asserted, up to MAX_HOLD cycles, then ownership is forced to rotate so no requester can starve the others. It sits between the requesters and the shared datapath. It is the clocked, fairness-enforcing counterpart to the combinational fixed-priority arbiter already in this design.

## Interface
- WIDTH, 4, number of requesters; must be ≥ 2.
- MAX_HOLD, 8, maximum number of consecutive cycles one grant may stay asserted; must be ≥ 1.
- IDW, $clog2(WIDTH), width of grant_id (localparam, derived).

- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  WIDTH  request vector, one bit per requester; level-sensitive.
- grant  output  WIDTH  registered one-hot grant; all-zero when no owner.
- grant_valid  output  1  high when grant is non-zero.
- grant_id  output  IDW  index of the current owner; 0 when grant_valid is low.
- timeout  output  1  one-cycle pulse, asserted in the cycle after a forced rotation at MAX_HOLD.

## Operation
- State machine has two states:
  - IDLE: no owner.
  - BUSY: one owner, grant[owner]=1.
- Internal registers:
  - ptr (IDW bits): index of the last granted requester.
  - hold_cnt: counts 1..MAX_HOLD.
- Search order: ptr+1, ptr+2, …, wrapping modulo WIDTH, ending at ptr itself. The first set req bit in this order wins.
- IDLE:
  - If req has any bit set: go to BUSY, owner = winner, ptr = winner, hold_cnt = 1.
  - Otherwise stay in IDLE.
- BUSY, owner's req low (normal release):
  - If any other req is set: go directly to the next winner (no gap cycle), ptr = winner, hold_cnt = 1.
  - Otherwise go to IDLE, grant = 0.
- BUSY, owner's req high, hold_cnt < MAX_HOLD: keep the owner, hold_cnt += 1.
- BUSY, owner's req high, hold_cnt == MAX_HOLD (forced rotation):
  - Grant the next winner; the owner is considered last in the search order.
  - If the owner is the only requester, it is re-granted.
  - hold_cnt = 1 and timeout pulses in both cases.
- ptr updates only when a grant is issued, never in IDLE.
- Requests are not latched. A req bit that drops before being served is simply lost.

## Timing
- Reset (async assert, any state):
  - grant = 0, grant_valid = 0, grant_id = 0, timeout = 0.
  - State = IDLE, ptr = WIDTH-1 (so requester 0 has first priority), hold_cnt = 0.
  - Outputs clear immediately on reset assertion, without waiting for a clock edge.
- Reset mid-grant drops the grant immediately. After release, the first grant follows the reset priority order.
- Latency from req rising in IDLE to grant: 1 cycle (grant appears after the first rising edge that samples req).
- Release latency: owner's req sampled low at edge N means grant[owner] = 0 from edge N. The next owner's grant is visible in the same cycle; handover takes one edge and there is never overlap.
- Maximum continuous grant: MAX_HOLD cycles. With MAX_HOLD = 1, ownership re-arbitrates every cycle.
- All outputs are registered; there is no combinational path from req to any output.
- grant is always one-hot or zero. grant_id and grant_valid change on the same edge as grant.

## Test plan
- Reset then req=4'b0000 for 5 cycles -> grant=0, grant_valid=0, timeout=0 throughout.
- req=4'b1111 held, MAX_HOLD=8 -> grant sequence 0001 (8 cycles), 0010 (8), 0100 (8), 1000 (8), 0001. timeout pulses once per rotation.
- req=4'b0100 for 3 cycles then 0 -> grant=0100 for exactly 3 cycles starting one edge after req. grant_id=2, no timeout, then IDLE.
- Only req[1] high for 20 cycles, MAX_HOLD=8 -> grant=0010 continuously. timeout pulses after cycles 8 and 16. hold_cnt restarts each time.
- Owner 0 releases at the edge where req=4'b1010 -> grant moves 0001 -> 0010 with no zero cycle. Then requester 1 releases -> grant=1000.
- rst asserted asynchronously while grant=0100 -> grant=0 before the next clk edge. After deassertion with req=4'b1100, the first grant is 0100.
